// File: rtl/dot_matrix_pkg.sv
// Shared state encoding and constants for the row-multiplexed dot-matrix scanner.
// Optional PWM dimming is built when `DOT_MATRIX_DIM_EN is defined.
package dot_matrix_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  localparam int PWM_BITS = 4;

  // Wide enough for any practical matrix; the top slices off ROWS bits.
  localparam int                  MAX_ROWS = 64;
  localparam logic [MAX_ROWS-1:0] ROW_OFF  = '1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dot_matrix_fb.sv
// Double-buffered ROWSxCOLS frame store: back-buffer write port, combinational front read, swap, clear.
// Writes land one cycle later; writes are dropped while the post-reset clear sequencer runs (no stall).
module dot_matrix_fb
  import dot_matrix_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW  = $clog2(ROWS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [RW-1:0]   wr_row_i,
  input  logic [COLS-1:0] wr_data_i,
  input  logic [RW-1:0]   rd_row_i,
  output logic [COLS-1:0] rd_data_o,
  input  logic            swap_i,
  output logic            clr_busy_o,
  output logic            clr_last_o
);

  localparam logic [RW:0]   ROWS_W   = ROWS[RW:0];
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [COLS-1:0] mem_q [2][ROWS];

  logic          front_q,    front_d;
  logic          clr_busy_q, clr_busy_d;
  logic [RW-1:0] clr_idx_q,  clr_idx_d;
  logic          wr_ok;

  assign clr_last_o = clr_busy_q && (clr_idx_q == ROW_LAST);
  assign clr_busy_o = clr_busy_q;
  assign wr_ok      = wr_en_i && !clr_busy_q && ({1'b0, wr_row_i} < ROWS_W);
  assign rd_data_o  = mem_q[front_q][rd_row_i];

  always_comb begin
    front_d    = front_q ^ swap_i;
    clr_busy_d = clr_busy_q && !clr_last_o;
    clr_idx_d  = clr_busy_q ? clr_idx_q + 1'b1 : clr_idx_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      front_q    <= 1'b0;
      clr_busy_q <= 1'b1;
      clr_idx_q  <= '0;
    end else begin
      front_q    <= front_d;
      clr_busy_q <= clr_busy_d;
      clr_idx_q  <= clr_idx_d;
    end
  end

  // Storage has no reset of its own: the sequencer wipes one row of each buffer per cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (clr_busy_q) begin
        mem_q[0][clr_idx_q] <= '0;
        mem_q[1][clr_idx_q] <= '0;
      end else if (wr_ok) begin
        mem_q[!front_q][wr_row_i] <= wr_data_i;
      end
    end
  end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-multiplexed LED matrix driver; registered pins change on the edge entering each BLANK/SHOW phase.
// No backpressure: writes/swap requests are always accepted; `DOT_MATRIX_DIM_EN adds brightness PWM.
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 16,
  parameter int BLANK = 1,
  localparam int RW   = $clog2(ROWS)
) (
  input  logic                div_clk_i,
  input  logic                rst_i,
`ifdef DOT_MATRIX_DIM_EN
  input  logic [PWM_BITS-1:0] brightness_i,
`endif
  input  logic                wr_en_i,
  input  logic [RW-1:0]       wr_row_i,
  input  logic [COLS-1:0]     wr_data_i,
  input  logic                swap_req_i,
  output logic                swap_done_o,
  output logic                frame_start_o,
  output logic [ROWS-1:0]     dot_row_o,
  output logic [COLS-1:0]     dot_col_o
);

  localparam int              CW         = $clog2(max_int(BLANK, DWELL) + 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROWS_OFF   = ROW_OFF[ROWS-1:0];

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic            swap_pending_q, swap_pending_d;
  logic            swap_done_q, swap_done_d;
  logic            frame_start_q, frame_start_d;
  logic [ROWS-1:0] dot_row_q, dot_row_d;
  logic [COLS-1:0] dot_col_q, dot_col_d;

  logic            show_row;
  logic            swap_now;
  logic            clr_busy;
  logic            clr_last;
  logic [COLS-1:0] front_row;

`ifdef DOT_MATRIX_DIM_EN
  logic [PWM_BITS-1:0] phase_q, phase_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
`endif

  dot_matrix_fb #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_fb (
    .clk_i      (div_clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_row_i   (wr_row_i),
    .wr_data_i  (wr_data_i),
    .rd_row_i   (row_idx_q),
    .rd_data_o  (front_row),
    .swap_i     (swap_now),
    .clr_busy_o (clr_busy),
    .clr_last_o (clr_last)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    row_idx_d      = row_idx_q;
    swap_pending_d = swap_pending_q | swap_req_i;
    swap_done_d    = 1'b0;
    frame_start_d  = 1'b0;
    swap_now       = 1'b0;
    show_row       = 1'b0;
    dot_row_d      = ROWS_OFF;
    dot_col_d      = '0;
`ifdef DOT_MATRIX_DIM_EN
    phase_d        = '0;
    bright_d       = bright_q;
`endif

    if (clr_busy) begin
      // Scan is parked until the frame store is clean; its first BLANK starts on the last clear cycle.
      state_d       = ST_BLANK;
      cnt_d         = '0;
      row_idx_d     = '0;
      frame_start_d = clr_last;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d  = ST_SHOW;
            cnt_d    = '0;
            show_row = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (row_idx_q == ROW_LAST) begin
              row_idx_d     = '0;
              frame_start_d = 1'b1;
              if (swap_pending_d) begin
                swap_now       = 1'b1;
                swap_done_d    = 1'b1;
                swap_pending_d = 1'b0;
              end
            end else begin
              row_idx_d = row_idx_q + 1'b1;
            end
          end else begin
            cnt_d    = cnt_q + 1'b1;
            show_row = 1'b1;
`ifdef DOT_MATRIX_DIM_EN
            phase_d  = phase_q + 1'b1;
`endif
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end

`ifdef DOT_MATRIX_DIM_EN
    if (frame_start_d) begin
      bright_d = brightness_i;
    end
`endif

    if (show_row) begin
      dot_row_d[row_idx_q] = 1'b0;
      dot_col_d            = front_row;
`ifdef DOT_MATRIX_DIM_EN
      if (phase_d > bright_q) begin
        dot_col_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge div_clk_i) begin
    if (rst_i) begin
      state_q        <= ST_BLANK;
      cnt_q          <= '0;
      row_idx_q      <= '0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      dot_row_q      <= ROWS_OFF;
      dot_col_q      <= '0;
`ifdef DOT_MATRIX_DIM_EN
      phase_q        <= '0;
      bright_q       <= '1;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      row_idx_q      <= row_idx_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
      frame_start_q  <= frame_start_d;
      dot_row_q      <= dot_row_d;
      dot_col_q      <= dot_col_d;
`ifdef DOT_MATRIX_DIM_EN
      phase_q        <= phase_d;
      bright_q       <= bright_d;
`endif
    end
  end

  assign swap_done_o   = swap_done_q;
  assign frame_start_o = frame_start_q;
  assign dot_row_o     = dot_row_q;
  assign dot_col_o     = dot_col_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Bench for dot_matrix_scanner: directed scenarios plus random traffic against a time-based frame model.
// Build with `DOT_MATRIX_DIM_EN to cover the brightness PWM.
module tb_dot_matrix_scanner;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int BLANK = 1;
`ifdef DOT_MATRIX_DIM_EN
  localparam int DWELL = 16;
`else
  localparam int DWELL = 4;
`endif
  localparam int RW     = $clog2(ROWS);
  localparam int SLOT   = BLANK + DWELL;
  localparam int PERIOD = ROWS * SLOT;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [RW-1:0]   wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic            swap_req = 1'b0;
`ifdef DOT_MATRIX_DIM_EN
  logic [3:0]      brightness = 4'hF;
`endif
  logic            swap_done;
  logic            frame_start;
  logic [ROWS-1:0] dot_row;
  logic [COLS-1:0] dot_col;

  always #5 clk = ~clk;

  dot_matrix_scanner #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) dut (
`ifdef DOT_MATRIX_DIM_EN
    .brightness_i  (brightness),
`endif
    .div_clk_i     (clk),
    .rst_i         (rst),
    .wr_en_i       (wr_en),
    .wr_row_i      (wr_row),
    .wr_data_i     (wr_data),
    .swap_req_i    (swap_req),
    .swap_done_o   (swap_done),
    .frame_start_o (frame_start),
    .dot_row_o     (dot_row),
    .dot_col_o     (dot_col)
  );

  int n_vec = 0;
  int n_err = 0;
  int sd_seen = 0;

  // Reference model: scan position is derived from time elapsed since the first frame start.
  logic [COLS-1:0] m_buf [2][ROWS];
  int              m_front, m_pending, m_clr_left, m_t, m_bright;
  logic [ROWS-1:0] e_row;
  logic [COLS-1:0] e_col;
  logic            e_fs, e_sd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    int pos, r, w, ph;
    e_sd = 1'b0;
    if (rst) begin
      m_clr_left = ROWS;
      m_t        = -1;
      m_front    = 0;
      m_pending  = 0;
      m_bright   = 15;
      foreach (m_buf[i, j]) m_buf[i][j] = '0;
    end else begin
      if (swap_req) m_pending = 1;
      if (wr_en && m_clr_left == 0 && int'(wr_row) < ROWS) m_buf[1 - m_front][wr_row] = wr_data;
      if (m_clr_left > 0) begin
        m_clr_left--;
        if (m_clr_left == 0) m_t = 0;
      end else begin
        m_t++;
        if ((m_t % PERIOD) == 0 && m_pending != 0) begin
          m_front   = 1 - m_front;
          m_pending = 0;
          e_sd      = 1'b1;
        end
      end
    end
    e_row = '1;
    e_col = '0;
    e_fs  = 1'b0;
    if (m_t >= 0) begin
      pos  = m_t % PERIOD;
      r    = pos / SLOT;
      w    = pos % SLOT;
      e_fs = (pos == 0);
`ifdef DOT_MATRIX_DIM_EN
      if (e_fs) m_bright = int'(brightness);
`endif
      if (w >= BLANK) begin
        e_row[r] = 1'b0;
        e_col    = m_buf[m_front][r];
`ifdef DOT_MATRIX_DIM_EN
        ph = (w - BLANK) % 16;
        if (ph > m_bright) e_col = '0;
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("dot_row", dot_row, e_row);
    check_eq("dot_col", dot_col, e_col);
    check_eq("frame_start", frame_start, e_fs);
    check_eq("swap_done", swap_done, e_sd);
    if (swap_done) sd_seen++;
  endtask

  task automatic run_until_pos(input int p);
    for (int k = 0; k < 2 * PERIOD + ROWS + 8; k++) begin
      if (m_t >= 0 && (m_t % PERIOD) == p) return;
      step();
    end
    check_eq("wait_pos", m_t % PERIOD, p);
  endtask

  task automatic write_row(input int r, input logic [COLS-1:0] d);
    wr_en   = 1'b1;
    wr_row  = RW'(r);
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  logic [COLS-1:0] pattern [ROWS];
  int              lit_cnt;

  initial begin
    pattern = '{8'h18, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E};

    // Reset, clear window and idle frames
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("reset_row_off", dot_row, 8'hFF);
    repeat (2 * PERIOD + ROWS + 4) step();

    // Load a bitmap and request a swap
    for (int r = 0; r < ROWS; r++) write_row(r, pattern[r]);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    run_until_pos(0);
    run_until_pos(3 * SLOT + BLANK);
    check_eq("row3_bitmap", dot_col, 8'hC3);

    // Back-buffer write stays hidden until a swap
    write_row(3, 8'hFF);
    repeat (3 * PERIOD) step();
    run_until_pos(3 * SLOT + BLANK);
    check_eq("row3_unswapped", dot_col, 8'hC3);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    run_until_pos(3 * SLOT + BLANK);
    check_eq("row3_swapped", dot_col, 8'hFF);

    // Three requests inside one frame merge into one swap
    run_until_pos(2);
    sd_seen = 0;
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (5) step();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (10) step();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (PERIOD - 18) step();
    check_eq("merged_swaps", sd_seen, 1);

    // Request landing in the boundary cycle swaps at that boundary
    run_until_pos(PERIOD - 1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check_eq("boundary_swap", swap_done, 1);

`ifdef DOT_MATRIX_DIM_EN
    // Brightness 3 lights a row for 4 of 16 SHOW cycles
    brightness = 4'd3;
    step();
    run_until_pos(0);
    run_until_pos(3 * SLOT + BLANK);
    lit_cnt = (dot_col != 0) ? 1 : 0;
    brightness = 4'd15;
    for (int k = 1; k < DWELL; k++) begin
      step();
      if (dot_col != 0) lit_cnt++;
    end
    check_eq("dim_lit_cycles", lit_cnt, 4);
    run_until_pos(5 * SLOT + BLANK + 7);
`else
    lit_cnt = 0;
`endif

    // Reset in the middle of row 5 SHOW
    run_until_pos(5 * SLOT + BLANK + 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midscan_rst_row", dot_row, 8'hFF);
    check_eq("midscan_rst_col", dot_col, 0);
    repeat (PERIOD + ROWS + 4) step();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_row   = RW'($urandom);
      wr_data  = COLS'($urandom);
      swap_req = ($urandom_range(0, 59) == 0);
      rst      = ($urandom_range(0, 999) == 0);
`ifdef DOT_MATRIX_DIM_EN
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
`endif
      step();
    end
    rst = 1'b0;
    wr_en = 1'b0;
    swap_req = 1'b0;
    repeat (PERIOD) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
